bcd_scan_display: RTL and testbench
===================================

Name: bcd_scan_display

Overview:
- Parametrised successor to the fixed 3-digit BCD/mux/seven-segment display path used beside the ALU datapath.
- Converts a DATA_W-bit unsigned result to BCD sequentially using shift-add-3 (double-dabble), one bit per clock.
- Latches the converted result into a stable display buffer and time-multiplexes DIGITS common-anode digits.
- Adds leading-zero blanking, overflow indication (all dashes) and an optional letter digit in the top position.

Parameters:
- DATA_W, 9: width of the binary input.
- DIGITS, 4: number of physical digits and anodes (≥2).
- SCAN_DIV, 4: clock cycles each digit stays active (≥1).
- BLANK_LZ, 1: 1 = blank leading zeros; 0 = show all zeros.

Ports:
- Clk, input, 1: system clock, all state on rising edge.
- Reset, input, 1: asynchronous, active-high reset.
- bin_in, input, DATA_W: unsigned value to display, sampled on load.
- load, input, 1: start conversion; honoured only when busy=0.
- letter_en, input, 1: 1 = top digit shows letter_in (live, not latched).
- letter_in, input, 4: letter code 0–F, shown as hex glyph 0–9,A,b,C,d,E,F.
- busy, output, 1: conversion in progress.
- done, output, 1: one-cycle pulse when the display buffer updates.
- AN, output, DIGITS: anode enables, active-low, one-hot-low while scanning.
- seven_seg, output, 7: {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (async): busy=0, done=0, AN=all 1s, seven_seg=7'h7F, display buffer=0, ovf flag=0, scan index=0, divider=0.
- Conversion:
  - Load edge (load=1, busy=0): capture bin_in, clear BCD shift register (DIGITS nibbles), set busy=1, iteration count=DATA_W.
  - Each following edge: add 3 to every nibble ≥5, then shift left 1 with the next bin MSB entering.
  - A 1 shifted out of the top nibble sets internal ovf.
  - On the edge completing iteration DATA_W: busy←0, done←1 for exactly one cycle, display buffer←BCD, ovf buffered.
  - busy is high for exactly DATA_W cycles; done is asserted DATA_W cycles after the load edge.
- load while busy=1 is ignored; bin_in changes during conversion have no effect.
- Display buffer holds its old value until done, so there is no flicker mid-conversion.
- Scan:
  - Divider counts 0..SCAN_DIV-1.
  - On wrap, scan index increments modulo DIGITS and AN←~(1<<index).
  - First AN activation (digit 0) occurs SCAN_DIV cycles after reset release.
  - seven_seg is registered together with AN so both change on the same edge.
- Glyph selection for digit i, in priority order:
  1. letter_en=1 and i=DIGITS-1 → letter glyph.
  2. Overflow condition → dash (7'b0111111). Overflow = buffered ovf=1, or letter_en=1 with top BCD nibble ≠0. Applies to all numeric digits.
  3. BLANK_LZ=1, i>0 and nibble i plus all higher numeric nibbles are 0 → blank (7'h7F).
  4. Otherwise → decimal glyph of nibble i.
- Digit 0 is never blanked, so a value of 0 shows "0".
- Letter glyph tracks letter_en/letter_in at the next scan edge showing the top digit.
- Reset mid-conversion aborts it: busy=0, no done pulse, buffer=0.
- Standard glyphs (active-low {g..a}): 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78, 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E.

Test Plan:
- Reset: assert Reset asynchronously mid-cycle → AN=4'b1111, seven_seg=7'h7F, busy=0, done=0 immediately; after release, AN=4'b1110 exactly 4 cycles later showing 7'h40 ("0").
- Normal conversion: load with bin_in=255 (defaults) → busy high 9 cycles, done pulse on the 9th edge after load; scan shows digit0=7'h12, digit1=7'h12, digit2=7'h24, digit3=7'h7F.
- Letter digit: load 37, letter_en=1, letter_in=4'hA → digit3=7'h08, digit2=7'h7F, digit1=7'h30, digit0=7'h78. With BLANK_LZ=0 → digit2=7'h40.
- Overflow: DATA_W=12, DIGITS=3, load 1000 → all three digits 7'b0111111. Then load 999 → "999".
- Load during busy: load 100, pulse load with bin_in=7 at cycle 4 → single done at cycle 9, display "100".
- Reset at cycle 5 of a conversion → no done pulse, display shows "0", next load converts normally.

Source files
------------

// File: rtl/bcd_scan_display.sv
// Sequential double-dabble BCD converter feeding a latched, time-multiplexed
// common-anode seven-segment display with blanking, overflow dashes and a letter digit.
module bcd_scan_display #(
  parameter int unsigned DATA_W   = 9,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 4,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [DATA_W-1:0] bin_in,
  input  logic              load,
  input  logic              letter_en,
  input  logic [3:0]        letter_in,
  output logic              busy,
  output logic              done,
  output logic [DIGITS-1:0] AN,
  output logic [6:0]        seven_seg
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam int unsigned IdxW = $clog2(DIGITS);
  localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(DATA_W);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
  localparam logic [6:0] SegDash  = 7'b0111111;
  localparam logic [6:0] SegBlank = 7'h7F;

  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
      4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
      4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
      4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
    endcase
    return g;
  endfunction

  logic [DATA_W-1:0] bin_q;
  logic [BcdW-1:0]   bcd_q, bcd_adj, bcd_next, disp_q;
  logic [CntW-1:0]   cnt_q;
  logic              busy_q, done_q, ovf_q, disp_ovf_q, shift_out;

  // One double-dabble iteration: add-3 correction, then shift in the next binary MSB.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    {shift_out, bcd_next} = {bcd_adj, bin_q[DATA_W-1]};
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      bin_q      <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      disp_q     <= '0;
      disp_ovf_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (load) begin
          bin_q  <= bin_in;
          bcd_q  <= '0;
          ovf_q  <= 1'b0;
          cnt_q  <= CntInit;
          busy_q <= 1'b1;
        end
      end else begin
        bcd_q <= bcd_next;
        bin_q <= bin_q << 1;
        ovf_q <= ovf_q | shift_out;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == CntOne) begin
          busy_q     <= 1'b0;
          done_q     <= 1'b1;
          disp_q     <= bcd_next;
          disp_ovf_q <= ovf_q | shift_out;
        end
      end
    end
  end

  logic [DivW-1:0]   div_q;
  logic [IdxW-1:0]   idx_q;
  logic [DIGITS-1:0] an_q;
  logic [6:0]        seg_q, seg_sel;
  logic              any_ovf, upper_zero;
  logic [3:0]        cur_nib;

  always_comb begin
    any_ovf    = disp_ovf_q | (letter_en & (disp_q[BcdW-1 -: 4] != 4'd0));
    upper_zero = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (i >= int'(idx_q) && disp_q[4*i +: 4] != 4'd0) upper_zero = 1'b0;
    end
    cur_nib = disp_q[4*int'(idx_q) +: 4];
    if (letter_en && idx_q == IdxLast) begin
      seg_sel = hex_glyph(letter_in);
    end else if (any_ovf) begin
      seg_sel = SegDash;
    end else if (BLANK_LZ != 0 && idx_q != '0 && upper_zero) begin
      seg_sel = SegBlank;
    end else begin
      seg_sel = hex_glyph(cur_nib);
    end
  end

  // AN and segments are registered together so a digit never shows its neighbour's glyph.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      div_q <= '0;
      idx_q <= '0;
      an_q  <= '1;
      seg_q <= SegBlank;
    end else if (div_q == DivLast) begin
      div_q <= '0;
      an_q  <= ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_q);
      seg_q <= seg_sel;
      idx_q <= (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign AN        = an_q;
  assign seven_seg = seg_q;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed bench for bcd_scan_display: default build, a no-blanking build and a
// 12-bit/3-digit build used to exercise overflow.
module tb_bcd_scan_display;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [8:0]  bin9;
  logic [11:0] bin12;
  logic        load, letter_en;
  logic [3:0]  letter_in;
  logic        busy0, busy1, busy2, done0, done1, done2;
  logic [3:0]  an0, an1;
  logic [2:0]  an2;
  logic [6:0]  seg0, seg1, seg2;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int sel = 0;
  logic [3:0] an_m;
  logic [6:0] seg_m;

  always #5 Clk = ~Clk;

  bcd_scan_display u_dut (
    .Clk(Clk), .Reset(Reset), .bin_in(bin9), .load(load), .letter_en(letter_en),
    .letter_in(letter_in), .busy(busy0), .done(done0), .AN(an0), .seven_seg(seg0)
  );

  bcd_scan_display #(.BLANK_LZ(0)) u_nlz (
    .Clk(Clk), .Reset(Reset), .bin_in(bin9), .load(load), .letter_en(letter_en),
    .letter_in(letter_in), .busy(busy1), .done(done1), .AN(an1), .seven_seg(seg1)
  );

  bcd_scan_display #(.DATA_W(12), .DIGITS(3)) u_ovf (
    .Clk(Clk), .Reset(Reset), .bin_in(bin12), .load(load), .letter_en(1'b0),
    .letter_in(4'h0), .busy(busy2), .done(done2), .AN(an2), .seven_seg(seg2)
  );

  always @(negedge Clk) if (done0) done_cnt <= done_cnt + 1;

  always_comb begin
    case (sel)
      0:       begin an_m = an0;          seg_m = seg0; end
      1:       begin an_m = an1;          seg_m = seg1; end
      default: begin an_m = {1'b1, an2};  seg_m = seg2; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits for a fresh activation of digit d so the glyph reflects the current buffer.
  task automatic get_digit(input int s, input int d, output logic [6:0] seg);
    logic [3:0] tgt;
    int n;
    tgt = ~(4'b0001 << d);
    sel = s;
    n = 0;
    #0;
    while (an_m == tgt && n < 100) begin @(negedge Clk); n++; end
    while (an_m != tgt && n < 100) begin @(negedge Clk); n++; end
    if (n >= 100) begin
      check("scan_timeout", 32'(n), 32'd0);
      seg = 'x;
    end else begin
      seg = seg_m;
    end
  endtask

  task automatic do_load(input logic [8:0] b, input logic [11:0] b12);
    @(negedge Clk);
    bin9  = b;
    bin12 = b12;
    load  = 1'b1;
    @(negedge Clk);
    load  = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy0 || busy1 || busy2) && n < 50) begin @(negedge Clk); n++; end
    if (n >= 50) check("idle_timeout", 32'(n), 32'd0);
    repeat (2) @(negedge Clk);
  endtask

  task automatic check_digits(input int s, input string tag, input logic [6:0] e0,
                              input logic [6:0] e1, input logic [6:0] e2, input logic [6:0] e3,
                              input int nd);
    logic [6:0] g;
    get_digit(s, 0, g); check({tag, "_d0"}, 32'(g), 32'(e0));
    get_digit(s, 1, g); check({tag, "_d1"}, 32'(g), 32'(e1));
    get_digit(s, 2, g); check({tag, "_d2"}, 32'(g), 32'(e2));
    if (nd > 3) begin
      get_digit(s, 3, g); check({tag, "_d3"}, 32'(g), 32'(e3));
    end
  endtask

  initial begin
    int n, d_before;
    logic [6:0] g;
    Reset = 1'b1; load = 1'b0; bin9 = '0; bin12 = '0; letter_en = 1'b0; letter_in = '0;
    #1;
    check("rst_an", 32'(an0), 32'hF);
    check("rst_seg", 32'(seg0), 32'h7F);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check("scan_not_yet", 32'(an0), 32'hF);
    @(negedge Clk);
    check("scan_first_an", 32'(an0), 32'hE);
    check("scan_first_seg", 32'(seg0), 32'h40);

    // 255: busy for 9 cycles, done on the 9th edge after load
    do_load(9'd255, 12'd0);
    n = 0;
    while (busy0 && n < 30) begin n++; @(negedge Clk); end
    check("busy_cycles", 32'(n), 32'd9);
    check("done_pulse", 32'(done0), 32'd1);
    @(negedge Clk);
    check("done_one_cycle", 32'(done0), 32'd0);
    wait_idle();
    check_digits(0, "v255", 7'h12, 7'h12, 7'h24, 7'h7F, 4);

    // 37 with letter A on top
    letter_en = 1'b1;
    letter_in = 4'hA;
    do_load(9'd37, 12'd0);
    wait_idle();
    check_digits(0, "let", 7'h78, 7'h30, 7'h7F, 7'h08, 4);
    get_digit(1, 2, g);
    check("let_nlz_d2", 32'(g), 32'h40);
    letter_en = 1'b0;

    // 12-bit/3-digit: 1000 overflows, 999 fits
    do_load(9'd0, 12'd1000);
    wait_idle();
    check_digits(2, "ovf", 7'h3F, 7'h3F, 7'h3F, 7'h00, 3);
    do_load(9'd0, 12'd999);
    wait_idle();
    check_digits(2, "v999", 7'h10, 7'h10, 7'h10, 7'h00, 3);

    // Second load mid-conversion is ignored
    d_before = done_cnt;
    do_load(9'd100, 12'd0);
    repeat (3) @(negedge Clk);
    bin9 = 9'd7;
    load = 1'b1;
    @(negedge Clk);
    load = 1'b0;
    wait_idle();
    repeat (4) @(negedge Clk);
    check("busy_load_done_cnt", 32'(done_cnt - d_before), 32'd1);
    check_digits(0, "v100", 7'h40, 7'h40, 7'h79, 7'h7F, 4);

    // Asynchronous reset mid-conversion aborts it
    d_before = done_cnt;
    do_load(9'd255, 12'd0);
    repeat (4) @(negedge Clk);
    @(posedge Clk);
    #3 Reset = 1'b1;
    #1;
    check("mid_rst_an", 32'(an0), 32'hF);
    check("mid_rst_seg", 32'(seg0), 32'h7F);
    check("mid_rst_busy", 32'(busy0), 32'd0);
    check("mid_rst_done", 32'(done0), 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (20) @(negedge Clk);
    check("abort_no_done", 32'(done_cnt - d_before), 32'd0);
    check("abort_busy", 32'(busy0), 32'd0);
    get_digit(0, 0, g); check("abort_d0", 32'(g), 32'h40);
    get_digit(0, 1, g); check("abort_d1", 32'(g), 32'h7F);
    do_load(9'd42, 12'd0);
    wait_idle();
    get_digit(0, 0, g); check("v42_d0", 32'(g), 32'h24);
    get_digit(0, 1, g); check("v42_d1", 32'(g), 32'h19);
    get_digit(0, 2, g); check("v42_d2", 32'(g), 32'h7F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
